// File: rtl/toysram_io_pkg.sv
// Shared types and helpers for the nibble-serial SRAM bridge.
//   state_e  : frame FSM states
//   CMD_RD/WR: command codes carried in the low two bits of the command beat
//   ceil_div : integer ceiling divide, used for beat counts
package toysram_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    REQ,
    RESP
  } state_e;

  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/io_shift.sv
// Parametrised shift register stepping STEP bits per shift, MSB-first.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents)
//   load       : parallel load of load_val (takes priority over shift)
//   shift      : shift left by STEP, sin enters at the bottom
//   q          : current contents; the top STEP bits are the serial output
module io_shift #(
  parameter int W    = 32,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [W-1:0]    load_val,
  input  logic            shift,
  input  logic [STEP-1:0] sin,
  output logic [W-1:0]    q
);

  logic [W-1:0]      q_d, q_q;
  logic [W+STEP-1:0] shift_cat;
  logic              unused_top;

  // Concatenate then keep the low W bits so the shift also works when W == STEP.
  assign shift_cat  = {q_q, sin};
  assign unused_top = ^shift_cat[W+STEP-1:W];

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = shift_cat[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/io_intf_ser.sv
// Nibble-serial to parallel SRAM bridge.
// A frame is: command beat, ceil(ADDR_BITS/PIN_W) address beats, and for
// writes BITS/PIN_W data beats, all MSB-first. One SRAM access is issued per
// frame; read data is returned as BITS/PIN_W output beats under ready/valid.
//   clk, reset                 : clock, asynchronous active-low reset
//   io_in/io_in_valid/io_in_busy: serial input beat, strobe, and busy (REQ/RESP)
//   io_out/io_out_valid/ready  : serial output beat with backpressure
//   mem_req/we/addr/wdata      : SRAM request, held until mem_ack
//   mem_ack/mem_rdata          : SRAM completion and read data
//   err                        : one-cycle pulse on a bad command or timeout
module io_intf_ser
  import toysram_io_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int ADDR_BITS = 6,
  parameter int PIN_W     = 4,
  parameter int TIMEOUT   = 255
) (
`ifdef USE_POWER_PINS
  inout  wire                  vdda1,
  inout  wire                  vdda2,
  inout  wire                  vssa1,
  inout  wire                  vssa2,
  inout  wire                  vccd1,
  inout  wire                  vccd2,
  inout  wire                  vssd1,
  inout  wire                  vssd2,
`endif
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIN_W-1:0]     io_in,
  input  logic                 io_in_valid,
  output logic                 io_in_busy,
  output logic [PIN_W-1:0]     io_out,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [BITS-1:0]      mem_wdata,
  input  logic                 mem_ack,
  input  logic [BITS-1:0]      mem_rdata,
  output logic                 err
);

  localparam int AB    = ceil_div(ADDR_BITS, PIN_W);
  localparam int DB    = BITS / PIN_W;
  localparam int AW    = AB * PIN_W;
  localparam int W_IN  = (AW > BITS) ? AW : BITS;
  localparam int CNT_W = $clog2(((AB > DB) ? AB : DB) + 1);
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [TO_W-1:0]      to_d, to_q;
  logic                 we_d, we_q;
  logic [ADDR_BITS-1:0] addr_d, addr_q;
  logic                 err_d, err_q;

  logic                 busy, beat_acc, to_hit;
  logic                 sipo_load, sipo_shift, piso_load, piso_shift;
  logic [W_IN-1:0]      sipo_q;
  logic [BITS-1:0]      piso_q;
  logic [W_IN+PIN_W-1:0] sipo_cat;
  logic                 unused_bits;

  assign busy     = (state_q == REQ) || (state_q == RESP);
  assign beat_acc = io_in_valid && !busy;
  // Timeout fires on the idle cycle that would take the counter to TIMEOUT.
  assign to_hit   = (TIMEOUT != 0) && (to_q == TO_W'(TIMEOUT - 1));
  // Value the input shifter would hold after taking the current beat; the
  // address is sliced from it so excess high address bits fall away.
  assign sipo_cat    = {sipo_q, io_in};
  assign unused_bits = ^{sipo_cat, piso_q};

  io_shift #(.W(W_IN), .STEP(PIN_W)) u_sipo (
    .clk      (clk),
    .rst_n    (reset),
    .load     (sipo_load),
    .load_val ('0),
    .shift    (sipo_shift),
    .sin      (io_in),
    .q        (sipo_q)
  );

  io_shift #(.W(BITS), .STEP(PIN_W)) u_piso (
    .clk      (clk),
    .rst_n    (reset),
    .load     (piso_load),
    .load_val (mem_rdata),
    .shift    (piso_shift),
    .sin      ('0),
    .q        (piso_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    we_d       = we_q;
    addr_d     = addr_q;
    err_d      = 1'b0;
    sipo_load  = 1'b0;
    sipo_shift = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat_acc) begin
          if (io_in[1:0] == CMD_RD || io_in[1:0] == CMD_WR) begin
            we_d      = (io_in[1:0] == CMD_WR);
            cnt_d     = '0;
            to_d      = '0;
            sipo_load = 1'b1;
            state_d   = ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (beat_acc) begin
          to_d = '0;
          if (cnt_q == CNT_W'(AB - 1)) begin
            addr_d    = sipo_cat[ADDR_BITS-1:0];
            sipo_load = 1'b1;       // start the data field from a clean shifter
            cnt_d     = '0;
            state_d   = we_q ? DATA : REQ;
          end else begin
            sipo_shift = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          to_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          to_d = to_q + TO_W'(1);
        end
      end
      DATA: begin
        if (beat_acc) begin
          to_d       = '0;
          sipo_shift = 1'b1;
          if (cnt_q == CNT_W'(DB - 1)) begin
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          to_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          to_d = to_q + TO_W'(1);
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (we_q) begin
            state_d = IDLE;
          end else begin
            piso_load = 1'b1;
            cnt_d     = '0;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (io_out_ready) begin
          piso_shift = 1'b1;
          if (cnt_q == CNT_W'(DB - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign io_in_busy   = busy;
  assign io_out_valid = (state_q == RESP);
  assign io_out       = piso_q[BITS-1 -: PIN_W];
  assign mem_req      = (state_q == REQ);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = sipo_q[BITS-1:0];
  assign err          = err_q;

endmodule

// File: doc/io_intf_ser.md
Name: io_intf_ser

Overview:
- Parametrised successor to the empty I/O interface macro.
- Bridges a narrow, pin-limited nibble-serial port from the Caravel GPIOs to a parallel single-port SRAM request/ack interface.
- Deserialises command, address and write data, and issues one SRAM access per frame.
- For reads, serialises the read data back out with ready/valid backpressure. A mid-frame inactivity timeout aborts stalled frames.

Parameters:
- BITS, 32: SRAM data width. Must be a multiple of PIN_W.
- ADDR_BITS, 6: SRAM address width.
- PIN_W, 4: serial beat width. Must be at least 2.
- TIMEOUT, 255: maximum idle cycles between beats inside a frame. 0 disables the timeout.

Ports:
- clk  in  1  Single clock; all logic is on its rising edge.
- reset  in  1  Asynchronous, active-low reset.
- vdda1..vssd2  inout  1  Power pins, present only under USE_POWER_PINS (same eight as the existing macro).
- io_in  in  PIN_W  Serial input beat.
- io_in_valid  in  1  Beat strobe; a beat is accepted when io_in_valid=1 and io_in_busy=0.
- io_in_busy  out  1  High in the REQ and RESP states; beats offered while high are ignored.
- io_out  out  PIN_W  Serial output beat.
- io_out_valid  out  1  Output beat is valid.
- io_out_ready  in  1  Consumer accepts io_out this cycle.
- mem_req  out  1  SRAM request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_BITS  SRAM address.
- mem_wdata  out  BITS  SRAM write data.
- mem_ack  in  1  SRAM completion; valid only while mem_req=1.
- mem_rdata  in  BITS  Read data, valid on the mem_ack cycle.
- err  out  1  One-cycle pulse on a bad command or a timeout.

Behaviour:
- Derived constants:
  - AB = ceil(ADDR_BITS/PIN_W) address beats.
  - DB = BITS/PIN_W data beats.
  - All fields are MSB-first.
  - Address bits above ADDR_BITS in the first address beat are discarded.
- Reset (async assert, sync release): state=IDLE, all outputs 0, shift registers and counters cleared. Reset mid-frame or mid-RESP drops the transaction; no partial mem_req is issued.
- IDLE: an accepted beat is the command; cmd[1:0] is decoded as follows.
  - 01 = read, 10 = write → go to ADDR.
  - Any other code → err=1 the next cycle; stay in IDLE.
  - Upper command bits are ignored.
- ADDR: shift in AB beats. After the last beat, go to DATA for a write or REQ for a read.
- DATA: shift in DB beats, then go to REQ.
- Timeout (ADDR/DATA only):
  - A counter clears on every accepted beat and increments otherwise.
  - When it reaches TIMEOUT, pulse err and go to IDLE.
  - A beat arriving in the same cycle the counter reaches TIMEOUT wins: it is accepted and the counter clears.
- REQ:
  - mem_req=1 is asserted the cycle after the last beat.
  - mem_we, mem_addr and mem_wdata are held stable until a cycle with mem_req=1 and mem_ack=1.
  - A write then returns to IDLE.
  - A read captures mem_rdata into the output shifter and goes to RESP.
  - mem_req drops the cycle after the ack.
- RESP:
  - io_out_valid=1 the cycle after the ack; io_out = top PIN_W bits of the shifter.
  - On io_out_valid & io_out_ready, shift and decrement the beat count.
  - After DB handshakes, go to IDLE; io_out_valid=0 the next cycle.
  - While io_out_ready=0, io_out is held stable with no timeout.
- Minimum frame latencies (defaults):
  - Write: 11 beats → mem_req one cycle later.
  - Read: 3 beats → mem_req +1 cycle; first io_out beat at ack +1 cycle.
- err never asserts outside IDLE, ADDR or DATA.

Decomposition:
- Package toysram_io_pkg holds:
  - the state enum (IDLE, ADDR, DATA, REQ, RESP);
  - the CMD_RD=2'b01 and CMD_WR=2'b10 constants;
  - a ceil-divide function for AB/DB.
- One sub-module, io_shift: a parametrised shift register (width, step PIN_W) with parallel load, serial in and serial out, used twice (input SIPO, output PISO).

Test Plan:
- Write: beats 2,2,A,D,E,A,D,B,E,E,F → mem_req=1, mem_we=1, mem_addr=0x2A, mem_wdata=0xDEADBEEF. Hold mem_ack=0 for 5 cycles → outputs stable; ack → mem_req=0 the next cycle, state IDLE.
- Read: beats 1,1,5 with mem_rdata=0x12345678 on ack → io_out sequence 1,2,3,4,5,6,7,8 with io_out_valid. Toggle io_out_ready every other cycle → no beat lost or duplicated. io_in_busy=1 throughout.
- Bad command: beat 3 (and separately beat 0) → single-cycle err, no mem_req. The following valid read frame completes normally.
- Timeout: cmd 2, one address beat, then idle 255 cycles → err pulse at cycle 255, state IDLE. With a beat at exactly cycle 255 → accepted, no err.
- Busy ignore: beats offered during REQ/RESP → ignored, and the next frame decodes correctly.
- Reset mid-RESP after 3 beats → all outputs 0 immediately. After release, a fresh read returns the correct data.
